// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Command front-end for the combinational ALU. Buffers
//               operand/opcode commands in a small FIFO, drives the ALU from
//               registers, captures result and flags one cycle later and
//               returns them with the command tag over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CONTROL    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_in1,
    input  logic [DATA_WIDTH-1:0] cmd_in2,
    input  logic [CONTROL-1:0]    cmd_opcode,
    input  logic [TAG_WIDTH-1:0]  cmd_tag,
    // ALU side
    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    output logic [CONTROL-1:0]    alu_opcode,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_parity,
    input  logic                  alu_zero,
    input  logic                  alu_sign,
    input  logic                  alu_carry,
    input  logic                  alu_aux,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic [4:0]            rsp_flags,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    // status
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  done_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRIVE = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    // FIFO storage, one array per command field
    logic [DATA_WIDTH-1:0] r_fifo_in1 [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_in2 [FIFO_DEPTH];
    logic [CONTROL-1:0]    r_fifo_op  [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  r_fifo_tag [FIFO_DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic [1:0]           r_state;
    logic [TAG_WIDTH-1:0] r_tag_lat;
    logic [1:0]           r_op_lat;

    logic       w_empty;
    logic       w_push;
    logic       w_handshake;
    logic       w_load;
    logic       w_keep_ca;
    logic [4:0] w_flags;

    // A full FIFO refuses a push even when it is being popped this cycle
    assign cmd_ready   = (r_count < c_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_push      = cmd_valid && cmd_ready;
    assign w_handshake = rsp_valid && rsp_ready;

    // Head entry is consumed from IDLE, or from HOLD on the response handshake
    assign w_load = !w_empty &&
                    ((r_state == c_ST_IDLE) ||
                     ((r_state == c_ST_HOLD) && w_handshake));

    // Carry and aux are only meaningful for opcodes with low bits 00
    assign w_keep_ca = (r_op_lat == 2'b00);
    assign w_flags   = {alu_aux & w_keep_ca, alu_carry & w_keep_ca,
                        alu_sign, alu_zero, alu_parity};

    assign busy = (r_state != c_ST_IDLE) || !w_empty;

    // FIFO payload write; storage needs no reset since count gates its use
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_in1[r_wr_ptr] <= cmd_in1;
            r_fifo_in2[r_wr_ptr] <= cmd_in2;
            r_fifo_op[r_wr_ptr]  <= cmd_opcode;
            r_fifo_tag[r_wr_ptr] <= cmd_tag;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue FSM: load ALU registers, capture result one cycle later, hold it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_opcode <= '0;
            r_tag_lat  <= '0;
            r_op_lat   <= 2'b00;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= 5'b00000;
            rsp_tag    <= '0;
            done_count <= '0;
        end else begin
            // The ALU registers keep their last value between operations
            if (w_load) begin
                alu_in1    <= r_fifo_in1[r_rd_ptr];
                alu_in2    <= r_fifo_in2[r_rd_ptr];
                alu_opcode <= r_fifo_op[r_rd_ptr];
                r_tag_lat  <= r_fifo_tag[r_rd_ptr];
                r_op_lat   <= r_fifo_op[r_rd_ptr][1:0];
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_load) begin
                        r_state <= c_ST_DRIVE;
                    end
                end
                c_ST_DRIVE: begin
                    rsp_result <= alu_out;
                    rsp_flags  <= w_flags;
                    rsp_tag    <= r_tag_lat;
                    rsp_valid  <= 1'b1;
                    r_state    <= c_ST_HOLD;
                end
                c_ST_HOLD: begin
                    if (w_handshake) begin
                        rsp_valid  <= 1'b0;
                        done_count <= done_count + CNT_WIDTH'(1);
                        r_state    <= w_load ? c_ST_DRIVE : c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl. A behavioural ALU
//               answers the DUT; hand-computed vectors, directed corner-case
//               sequences and a randomized run against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int DEPTH = 4;
    localparam int TW = 4;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_in1 = '0;
    logic [DW-1:0] cmd_in2 = '0;
    logic [CW-1:0] cmd_opcode = '0;
    logic [TW-1:0] cmd_tag = '0;
    logic [DW-1:0] alu_in1, alu_in2, alu_out;
    logic [CW-1:0] alu_opcode;
    logic          alu_parity, alu_zero, alu_sign, alu_carry, alu_aux;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_result;
    logic [4:0]    rsp_flags;
    logic [TW-1:0] rsp_tag;
    logic          busy;
    logic [NW-1:0] done_count;

    int n_checks = 0;
    int n_fail = 0;
    logic [NW-1:0] exp_done = '0;

    alu_issue_ctrl #(
        .DATA_WIDTH(DW), .CONTROL(CW), .FIFO_DEPTH(DEPTH),
        .TAG_WIDTH(TW), .CNT_WIDTH(NW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_in1(cmd_in1), .cmd_in2(cmd_in2),
        .cmd_opcode(cmd_opcode), .cmd_tag(cmd_tag),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_parity(alu_parity), .alu_zero(alu_zero),
        .alu_sign(alu_sign), .alu_carry(alu_carry), .alu_aux(alu_aux),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: {aux, carry, sign, zero, parity, result}.
    // Logic ops drive deliberately arbitrary carry/aux values.
    function automatic logic [36:0] alu_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [3:0] op);
        logic [32:0] wide;
        logic [31:0] r;
        logic        c, ax;
        c  = a[0] | b[0];
        ax = a[7] | b[2];
        case (op)
            4'b0000: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[31:0];
                c    = wide[32];
                ax   = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
            end
            4'b0100: begin
                r  = a - b;
                c  = (a < b);
                ax = (a[3:0] < b[3:0]);
            end
            4'b1110: r = a ^ b;
            4'b1000: r = a & b;
            4'b1001: r = a | b;
            default: r = a;
        endcase
        return {ax, c, r[31], (r == 32'd0), ~^r, r};
    endfunction

    assign {alu_aux, alu_carry, alu_sign, alu_zero, alu_parity, alu_out} =
        alu_model(alu_in1, alu_in2, alu_opcode);

    // Expected response: ALU answer with carry/aux hidden unless op[1:0]==00
    function automatic logic [36:0] exp_rsp(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [3:0] op);
        logic [36:0] v;
        v = alu_model(a, b, op);
        if (op[1:0] != 2'b00) v[36:35] = 2'b00;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_done = '0;
    endtask

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic [3:0]  tag;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    vec_t vecs[7];

    // One command through an empty block, checking the E1/E2 latency
    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_in1 = v.in1; cmd_in2 = v.in2;
        cmd_opcode = v.op; cmd_tag = v.tag;
        @(negedge clk);
        check("vec_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;          // E0
        cmd_valid = 1'b0;
        @(posedge clk); #1;          // E1
        check("vec_alu_in1", alu_in1, v.in1);
        check("vec_alu_in2", alu_in2, v.in2);
        check("vec_alu_opcode", alu_opcode, v.op);
        check("vec_rsp_valid_early", rsp_valid, 0);
        @(posedge clk); #1;          // E2
        check("vec_rsp_valid", rsp_valid, 1);
        check("vec_rsp_result", rsp_result, v.res);
        check("vec_rsp_flags", rsp_flags, v.flg);
        check("vec_rsp_tag", rsp_tag, v.tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_done++;
        check("vec_rsp_valid_cleared", rsp_valid, 0);
        check("vec_done_count", done_count, exp_done);
        check("vec_busy", busy, 0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [3:0] rnd_opcode();
        case ($urandom_range(0, 5))
            0:       return 4'b0000;
            1:       return 4'b0100;
            2:       return 4'b1110;
            3:       return 4'b1000;
            4:       return 4'b1001;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [36:0] q_exp[$];
        logic [3:0]  q_tag[$];
        logic [36:0] e;
        logic [3:0]  t;
        logic [3:0]  acc_tags[8];
        int          n_acc, n_rsp, last_c;
        logic [3:0]  rsp_tags[8];
        int          rsp_cyc[8];
        logic        saw, got;

        // in1, in2, op, tag, result, {aux,carry,sign,zero,parity}
        vecs[0] = '{32'd5,          32'd3,          4'b0000, 4'h7, 32'd8,          5'b00000};
        vecs[1] = '{32'd0,          32'd1,          4'b0100, 4'h1, 32'hFFFF_FFFF,  5'b11101};
        vecs[2] = '{32'hA5,         32'hA5,         4'b1110, 4'h2, 32'd0,          5'b00011};
        vecs[3] = '{32'hFFFF_FFFF,  32'd1,          4'b0000, 4'h3, 32'd0,          5'b11011};
        vecs[4] = '{32'h0F,         32'h01,         4'b0000, 4'h4, 32'h10,         5'b10000};
        vecs[5] = '{32'd7,          32'd2,          4'b0100, 4'h5, 32'd5,          5'b00001};
        vecs[6] = '{32'h8000_0000,  32'd1,          4'b1001, 4'hC, 32'h8000_0001,  5'b00101};

        // Reset state, with a command offered during reset
        rst_n = 1'b0;
        cmd_valid = 1'b1; cmd_in1 = 32'd9; cmd_tag = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_alu_in1", alu_in1, 0);
        check("rst_alu_in2", alu_in2, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_done_count", done_count, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 0);

        // Table-driven single operations
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Randomized traffic against the queue model
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            check("rnd_done_count", done_count, exp_done);
            cmd_valid  = ($urandom_range(0, 2) != 0);
            cmd_in1    = rnd_operand();
            cmd_in2    = rnd_operand();
            cmd_opcode = rnd_opcode();
            cmd_tag    = 4'($urandom_range(0, 15));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                if (q_exp.size() == 0) begin
                    flag_fail("rnd_unexpected_rsp");
                end else begin
                    e = q_exp.pop_front();
                    t = q_tag.pop_front();
                    check("rnd_result", rsp_result, e[31:0]);
                    check("rnd_flags", rsp_flags, e[36:32]);
                    check("rnd_tag", rsp_tag, t);
                end
                exp_done++;
            end
            if (cmd_valid && cmd_ready) begin
                q_exp.push_back(exp_rsp(cmd_in1, cmd_in2, cmd_opcode));
                q_tag.push_back(cmd_tag);
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && q_exp.size() > 0; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                e = q_exp.pop_front();
                t = q_tag.pop_front();
                check("drain_result", rsp_result, e[31:0]);
                check("drain_flags", rsp_flags, e[36:32]);
                check("drain_tag", rsp_tag, t);
                exp_done++;
            end
        end
        check("drain_empty", q_exp.size(), 0);
        @(posedge clk); #1;
        check("drain_done_count", done_count, exp_done);
        check("drain_busy", busy, 0);

        // Backpressure: 7 offers, 5 accepted, then in-order drain
        apply_reset();
        n_acc = 0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_tag = 4'(k); cmd_in1 = 32'(k);
            cmd_in2 = 32'd1; cmd_opcode = 4'b0000;
            @(negedge clk);
            if (cmd_ready) begin
                acc_tags[n_acc] = 4'(k);
                n_acc++;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("bp_accepted", n_acc, 5);
        for (int k = 0; k < n_acc && k < 5; k++) check("bp_acc_tag", acc_tags[k], k);
        check("bp_cmd_ready_full", cmd_ready, 0);
        check("bp_rsp_valid_held", rsp_valid, 1);
        rsp_ready = 1'b1;
        n_rsp = 0;
        for (int c = 0; c < 30 && n_rsp < 5; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                rsp_tags[n_rsp] = rsp_tag;
                rsp_cyc[n_rsp] = c;
                check("bp_result", rsp_result, n_rsp + 1);
                n_rsp++;
            end
        end
        check("bp_rsp_count", n_rsp, 5);
        last_c = -1;
        for (int k = 0; k < n_rsp; k++) begin
            check("bp_rsp_tag_order", rsp_tags[k], k);
            if (k > 0) check("bp_rsp_spacing", rsp_cyc[k] - last_c, 2);
            last_c = rsp_cyc[k];
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_done_count", done_count, 5);

        // Reset while holding a response with 3 entries buffered
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_tag = 4'(8 + k); cmd_in1 = 32'(k);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("mid_rsp_valid_before", rsp_valid, 1);
        check("mid_busy_before", busy, 1);
        check("mid_cmd_ready_before", cmd_ready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rsp_valid_rst", rsp_valid, 0);
        check("mid_busy_rst", busy, 0);
        check("mid_done_count_rst", done_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        check("mid_no_stale_rsp", saw, 0);
        check("mid_done_count_after", done_count, 0);
        check("mid_busy_after", busy, 0);

        // Counter wrap over 17 operations (CNT_WIDTH=4)
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_tag = 4'(i); cmd_in1 = 32'(i);
            cmd_in2 = 32'd0; cmd_opcode = 4'b0000;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (rsp_valid) got = 1'b1;
            end
            if (!got) begin
                flag_fail("wrap_rsp_timeout");
            end else begin
                @(posedge clk); #1;
                exp_done++;
                check("wrap_done_count", done_count, exp_done);
            end
        end
        check("wrap_final", done_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
